ghr_manager: RTL and testbench
==============================

# ghr_manager

Speculative global-history register feeding the tagged predictors' `global_history_i`. It shifts the predicted direction of each conditional branch into the history and snapshots the pre-shift history into a circular checkpoint buffer. On a branch misprediction it restores the history from the mispredicted branch's checkpoint and shifts in the resolved direction. It sits directly upstream of every tagged/base predictor bank and shares the front-end's prediction and backend-resolution interfaces.

## Interface

- `GHR_LENGTH`, 16: history length; output carries `GHR_LENGTH+1` bits, matching the predictors' one-extra-bit input.
- `CKPT_DEPTH`, 8: in-flight branch checkpoints; power of two, ≥2.
- `CKPT_ID_W`, `$clog2(CKPT_DEPTH)`: derived, not overridden.

Ports:

- `clk`, input, 1: clock.
- `rst_n`, input, 1: one clock; reset is asynchronous and active-low.
- `predict_valid_i`, input, 1: a conditional branch was predicted this cycle.
- `predict_taken_i`, input, 1: its predicted direction.
- `ckpt_id_o`, output, CKPT_ID_W: checkpoint id allocated to the current predict; travels with the branch.
- `full_o`, output, 1: all checkpoints in use; front-end must stall prediction.
- `empty_o`, output, 1: no checkpoints in use.
- `commit_valid_i`, input, 1: oldest in-flight branch retired correctly.
- `recover_valid_i`, input, 1: branch with `recover_id_i` mispredicted.
- `recover_id_i`, input, CKPT_ID_W: checkpoint id of the mispredicted branch.
- `recover_taken_i`, input, 1: resolved direction.
- `global_history_o`, output, GHR_LENGTH+1: speculative history; bit 0 newest.

## Operation

State:
- `ghr[GHR_LENGTH:0]`.
- `ckpt[CKPT_DEPTH]` of GHR_LENGTH+1 bits.
- `head`/`tail` pointers (CKPT_ID_W, wrap modulo CKPT_DEPTH).
- `count` ($clog2(CKPT_DEPTH+1) bits).

Behaviour:
- `ckpt_id_o = tail` (combinational).
- `full_o = (count == CKPT_DEPTH)`; `empty_o = (count == 0)`; both are decoded from registered count.
- Predict accepted when `predict_valid_i & ~full_o & ~recover_valid_i`:
  - `ckpt[tail] <= ghr`
  - `ghr <= {ghr[GHR_LENGTH-1:0], predict_taken_i}`
  - `tail++`, `count++`
- Predict while full or during recover: dropped, no state change.
- Commit accepted when `commit_valid_i & ~empty_o`: `head++`, `count--`. Commit while empty is ignored.
- Recover is valid when `off = (recover_id_i - head) mod CKPT_DEPTH` satisfies `off < count`. On a valid recover:
  - `ghr <= {ckpt[recover_id_i][GHR_LENGTH-1:0], recover_taken_i}`
  - `tail <= recover_id_i + 1`
  - `count <= off + 1`
  - All younger checkpoints are discarded. The recovered branch keeps its checkpoint until commit.
- Invalid recover id: ignored entirely.
- Recover + commit in the same cycle:
  - head advances.
  - `count <= off + 1 - 1 = off`.
  - Evaluation uses the pre-update head and count.
- Predict + commit in the same cycle: both apply; count is unchanged.
- Priority: recover > predict; commit is independent.

## Timing

- All state is registered. `global_history_o` reflects an accepted predict or recover on the next cycle; `full_o` and `empty_o` likewise.
- `ckpt_id_o` is valid in the same cycle as `predict_valid_i`.
- Throughput: one predict, one commit and one recover per cycle.
- Reset values:
  - `ghr`, `head`, `tail`, `count` = 0, so `global_history_o` = 0 and `ckpt_id_o` = 0.
  - `full_o` = 0, `empty_o` = 1.
  - Checkpoint contents = 0.
- Reset asserted mid-operation clears all state immediately (asynchronous); no stale checkpoint is observable after release.
- Pointer wrap: pointers wrap from `CKPT_DEPTH-1` to 0 silently. The occupancy test relies solely on `count`, never on a `head == tail` compare.

## Test plan

- **Reset and single predict.** Release reset, then predict taken=1, 1, 0. Expect `global_history_o` = 0 → 0x1 → 0x3 → 0x6. Expect ids 0, 1, 2 and `empty_o` falling after the first predict.
- **Fill and stall.** With `CKPT_DEPTH=8`, issue 9 back-to-back predicts. Expect `full_o`=1 after the 8th. The 9th is dropped: history unchanged, `count` stays 8.
- **Recover mid-stream.** Predict 1, 1, 1, 1 (ids 0–3; history 0xF), then recover id 1 with taken=0. Expect history 0x2 (ckpt[1]=0x1 shifted with 0) and `ckpt_id_o`=2 next cycle.
- **Recover + commit same cycle.** Four in flight (head=0). Recover id 0 with taken=1 while committing. Expect count=0, `empty_o`=1, head=tail=1, and history = ckpt[0] shifted in 1.
- **Invalid recover and empty commit.** With 2 in flight (ids 0–1), recover id 5. Expect no change. Commit 3 times: the third commit is ignored and `empty_o`=1.
- **Wrap-around.** Run 20 predict/commit pairs, then recover the youngest id (3, since tail=4). Verify the correct history is restored across the pointer wrap.

Source files
------------

// File: rtl/ghr_manager.sv
// ghr_manager: speculative global history with per-branch checkpoints and misprediction recovery
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   predict_valid_i/predict_taken_i predicted conditional branch and its direction
//   ckpt_id_o                       checkpoint id allocated to the current predict
//   full_o / empty_o                all / no checkpoints in use
//   commit_valid_i                  oldest in-flight branch retired
//   recover_valid_i/_id_i/_taken_i  mispredicted branch, its checkpoint and resolved direction
//   global_history_o                speculative history, bit 0 newest
module ghr_manager #(
  parameter int GHR_LENGTH = 16,
  parameter int CKPT_DEPTH = 8,
  parameter int CKPT_ID_W  = $clog2(CKPT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  predict_valid_i,
  input  logic                  predict_taken_i,
  output logic [CKPT_ID_W-1:0]  ckpt_id_o,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic                  commit_valid_i,
  input  logic                  recover_valid_i,
  input  logic [CKPT_ID_W-1:0]  recover_id_i,
  input  logic                  recover_taken_i,
  output logic [GHR_LENGTH:0]   global_history_o
);
  localparam int CNT_W = $clog2(CKPT_DEPTH + 1);
  logic [GHR_LENGTH:0]  ghr;
  logic [GHR_LENGTH:0]  ckpt [CKPT_DEPTH];
  logic [CKPT_ID_W-1:0] head, tail, off;
  logic [CNT_W-1:0]     count;
  logic                 pred_ok, com_ok, rec_ok;
  assign ckpt_id_o        = tail;
  assign full_o           = count == CNT_W'(CKPT_DEPTH);
  assign empty_o          = count == '0;
  assign global_history_o = ghr;
  // Distance from the oldest in-flight branch; wraps modulo the buffer depth.
  assign off     = recover_id_i - head;
  assign rec_ok  = recover_valid_i && (CNT_W'(off) < count);
  assign pred_ok = predict_valid_i && !full_o && !recover_valid_i;
  assign com_ok  = commit_valid_i && !empty_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ghr   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < CKPT_DEPTH; i++) ckpt[i] <= '0;
    end else begin
      if (pred_ok) ckpt[tail] <= ghr;
      if (com_ok) head <= head + CKPT_ID_W'(1);
      ghr   <= rec_ok  ? {ckpt[recover_id_i][GHR_LENGTH-1:0], recover_taken_i} :
               pred_ok ? {ghr[GHR_LENGTH-1:0], predict_taken_i} : ghr;
      tail  <= rec_ok  ? recover_id_i + CKPT_ID_W'(1) :
               pred_ok ? tail + CKPT_ID_W'(1) : tail;
      // The recovered branch keeps its slot (off + 1); a same-cycle commit retires one.
      count <= rec_ok ? CNT_W'(off) + CNT_W'(!com_ok) :
               count + CNT_W'(pred_ok) - CNT_W'(com_ok);
    end
endmodule

// File: tb/tb_ghr_manager.sv
// tb_ghr_manager: randomized and directed scoreboard bench for ghr_manager
module tb_ghr_manager;
  logic        clk = 0, rst_n = 0;
  logic        predict_valid_i = 0, predict_taken_i = 0, commit_valid_i = 0;
  logic        recover_valid_i = 0, recover_taken_i = 0;
  logic [2:0]  recover_id_i = 0, ckpt_id_o;
  logic        full_o, empty_o;
  logic [16:0] global_history_o;
  int          pass_cnt = 0, total_cnt = 0;

  typedef struct {logic [2:0] id; logic [16:0] h;} ent_t;
  typedef struct {logic [16:0] g; logic [2:0] id; logic f; logic e;} exp_t;
  ent_t        infl[$];
  exp_t        sb[$];
  logic [16:0] m_ghr = 0;
  logic [2:0]  m_tid = 0;

  ghr_manager dut (
    .clk(clk), .rst_n(rst_n),
    .predict_valid_i(predict_valid_i), .predict_taken_i(predict_taken_i),
    .ckpt_id_o(ckpt_id_o), .full_o(full_o), .empty_o(empty_o),
    .commit_valid_i(commit_valid_i), .recover_valid_i(recover_valid_i),
    .recover_id_i(recover_id_i), .recover_taken_i(recover_taken_i),
    .global_history_o(global_history_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] x);
    total_cnt++;
    if (a === x) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, x);
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.g = m_ghr; e.id = m_tid; e.f = infl.size() == 8; e.e = infl.size() == 0;
    return e;
  endfunction

  // Monitor: every cycle following a stimulus cycle the DUT presents its new state.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("history", 32'(global_history_o), 32'(e.g));
      chk("ckpt_id", 32'(ckpt_id_o), 32'(e.id));
      chk("full", 32'(full_o), 32'(e.f));
      chk("empty", 32'(empty_o), 32'(e.e));
    end
  end

  // Reference: in-flight branches as an ordered list, searched by id for recovery.
  task automatic model(bit pv, bit pt, bit cv, bit rv, logic [2:0] rid, bit rt);
    int  k = -1;
    bit  was_full = infl.size() == 8, was_empty = infl.size() == 0;
    if (rv) foreach (infl[i]) if (infl[i].id == rid) k = i;
    if (k >= 0) begin
      m_ghr = {infl[k].h[15:0], rt};
      while (infl.size() > k + 1) void'(infl.pop_back());
      m_tid = rid + 3'd1;
    end else if (pv && !was_full && !rv) begin
      infl.push_back('{m_tid, m_ghr});
      m_ghr = {m_ghr[15:0], pt};
      m_tid = m_tid + 3'd1;
    end
    if (cv && !was_empty) void'(infl.pop_front());
  endtask

  task automatic step(bit pv, bit pt, bit cv, bit rv, logic [2:0] rid, bit rt);
    @(negedge clk);
    #2;
    predict_valid_i = pv; predict_taken_i = pt; commit_valid_i = cv;
    recover_valid_i = rv; recover_id_i = rid; recover_taken_i = rt;
    model(pv, pt, cv, rv, rid, rt);
    sb.push_back(snap());
    @(posedge clk);
    #1;
    {predict_valid_i, predict_taken_i, commit_valid_i, recover_valid_i, recover_taken_i} = '0;
  endtask

  task automatic lit(logic [16:0] g, logic [2:0] id, bit f, bit e);
    @(negedge clk);
    #3;
    chk("lit_history", 32'(global_history_o), 32'(g));
    chk("lit_ckpt_id", 32'(ckpt_id_o), 32'(id));
    chk("lit_full", 32'(full_o), 32'(f));
    chk("lit_empty", 32'(empty_o), 32'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 0;
    infl.delete(); m_ghr = 0; m_tid = 0;
    #1;
    chk("async_rst_history", 32'(global_history_o), 0);
    chk("async_rst_empty", 32'(empty_o), 1);
    chk("async_rst_full", 32'(full_o), 0);
    chk("async_rst_id", 32'(ckpt_id_o), 0);
    @(negedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    logic [16:0] h;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1;
    lit(17'h0, 3'd0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    lit(17'h6, 3'd3, 0, 0);
    // Fill and stall: ninth predict is dropped.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    lit(17'hFF, 3'd0, 1, 0);
    // Recover mid-stream.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd1, 0);
    lit(17'h2, 3'd2, 0, 0);
    // Recover + commit on the oldest branch.
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 3'd0, 1);
    lit(17'h1, 3'd1, 0, 1);
    // Invalid recover id and commit while empty.
    do_reset();
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3'd5, 0);
    lit(17'h3, 3'd2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    lit(17'h3, 3'd2, 0, 1);
    // Wrap-around: recover the youngest branch after 20 predict/commit pairs.
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1'($urandom), 1, 0, 0, 0);
    h = infl[0].h;
    step(0, 0, 0, 1, 3'd3, 1);
    lit({h[15:0], 1'b1}, 3'd4, 0, 0);
    // Randomized traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 1, 3'($urandom_range(0, 7)), 1'($urandom));
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #5;
    if (sb.size() > 0) chk("drain", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
